// File: rtl/multi_expression_pipe.sv
// Three-stage fixed-point gain/offset scaler: Q = sat(round(K * (D - OFFSET) / 2^FRAC)).
// Valid/ready pipeline with per-stage valid bits, backpressure-safe, sticky saturation flags.
module multi_expression_pipe #(
  parameter int DW     = 8,
  parameter int KW     = 10,
  parameter int FRAC   = 8,
  parameter int RW     = 8,
  parameter int OFFSET = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] K,
  input  logic [DW-1:0] D,
  output logic          q_valid,
  input  logic          q_ready,
  output logic [RW-1:0] Q,
  output logic          q_sat_hi,
  output logic          q_sat_lo,
  input  logic          err_clr,
  output logic          err_hi,
  output logic          err_lo
);

  localparam int PW = KW + DW + 1;
  localparam int SW = PW + 1;
  localparam logic [DW:0]          OFF_V = (DW+1)'(OFFSET);
  localparam logic signed [SW-1:0] HALF  = SW'(2**(FRAC-1));
  localparam logic signed [SW-1:0] QMAX  = SW'(2**RW - 1);

  // One guard bit above the product keeps the rounding add from overflowing.
  function automatic logic [RW+1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [SW-1:0] r;
    r = (SW'(p) + HALF) >>> FRAC;
    if (r < 0)         round_sat = {2'b01, {RW{1'b0}}};
    else if (r > QMAX) round_sat = {2'b10, {RW{1'b1}}};
    else               round_sat = {2'b00, r[RW-1:0]};
  endfunction

  logic                 vld_p0_q, vld_p1_q, vld_p2_q;
  logic signed [KW-1:0] k_p0_q;
  logic signed [DW:0]   doff_p0_q, doff_p0_d;
  logic signed [PW-1:0] prod_p1_q, prod_p1_d;
  logic [RW+1:0]        res_p2_d;
  logic [RW-1:0]        q_p2_q;
  logic                 hi_p2_q, lo_p2_q;
  logic                 err_hi_q, err_hi_d, err_lo_q, err_lo_d;
  logic                 en_p0, en_p1, en_p2, out_xfer;

  // A stage may load when empty or when its content leaves this cycle.
  assign en_p2    = !vld_p2_q | q_ready;
  assign en_p1    = !vld_p1_q | en_p2;
  assign en_p0    = !vld_p0_q | en_p1;
  assign in_ready = en_p0;
  assign out_xfer = vld_p2_q & q_ready;

  assign doff_p0_d = $signed({1'b0, D}) - $signed(OFF_V);
  assign prod_p1_d = PW'(k_p0_q) * PW'(doff_p0_q);
  assign res_p2_d  = round_sat(prod_p1_q);

  assign err_hi_d = (err_hi_q & !err_clr) | (out_xfer & hi_p2_q);
  assign err_lo_d = (err_lo_q & !err_clr) | (out_xfer & lo_p2_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      q_p2_q   <= '0;
      hi_p2_q  <= 1'b0;
      lo_p2_q  <= 1'b0;
      err_hi_q <= 1'b0;
      err_lo_q <= 1'b0;
    end else begin
      if (en_p0) vld_p0_q <= in_valid;
      if (en_p1) vld_p1_q <= vld_p0_q;
      // S3: round/saturate boundary
      if (en_p2) begin
        vld_p2_q <= vld_p1_q;
        q_p2_q   <= res_p2_d[RW-1:0];
        hi_p2_q  <= res_p2_d[RW+1];
        lo_p2_q  <= res_p2_d[RW];
      end
      err_hi_q <= err_hi_d;
      err_lo_q <= err_lo_d;
    end
  end

  always_ff @(posedge clk) begin
    // S1: offset boundary
    if (en_p0) begin
      k_p0_q    <= $signed(K);
      doff_p0_q <= doff_p0_d;
    end
    // S2: multiply boundary
    if (en_p1) prod_p1_q <= prod_p1_d;
  end

  assign q_valid  = vld_p2_q;
  assign Q        = q_p2_q;
  assign q_sat_hi = hi_p2_q;
  assign q_sat_lo = lo_p2_q;
  assign err_hi   = err_hi_q;
  assign err_lo   = err_lo_q;

endmodule
